// File: rtl/pearson_pkg.sv
// pearson_pkg: Pearson permutation table, hash seed and miner FSM encodings
package pearson_pkg;
  localparam logic [7:0] HASH_INIT = 8'hAA;
  typedef enum logic [1:0] {IDLE = 2'd0, HASH = 2'd1, CHECK = 2'd2, DONE = 2'd3} state_t;
  function automatic logic [7:0] pearson_t(input logic [7:0] x);
    logic [7:0] y;
    y = x * 8'd167 + 8'd13;
    y = {y[2:0], y[7:3]} ^ 8'h5C;
    return y * 8'd29 + 8'd101;
  endfunction
endpackage

// File: rtl/pearson_round.sv
// pearson_round: one Pearson hash step, T[h ^ b]
module pearson_round
  import pearson_pkg::*;
(
  input  logic [7:0] i_h,
  input  logic [7:0] i_b,
  output logic [7:0] o_t
);
  assign o_t = pearson_t(i_h ^ i_b);
endmodule

// File: rtl/pow_nonce_miner.sv
// pow_nonce_miner: searches nonces 0..255 for the first Pearson hash below target
module pow_nonce_miner
  import pearson_pkg::*;
#(
  parameter int MSG_BYTES = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [8*MSG_BYTES-1:0] header,
  input  logic [7:0]             target,
  output logic                   busy,
  output logic                   done,
  output logic                   found,
  output logic [7:0]             nonce_out,
  output logic [7:0]             hash_out
);
  localparam logic [5:0] LAST = 6'(MSG_BYTES);
  state_t                 r_state;
  logic [8*MSG_BYTES-1:0] r_hdr;
  logic [8*MSG_BYTES-1:0] r_shift;
  logic [7:0]             r_tgt;
  logic [7:0]             r_nonce;
  logic [5:0]             r_idx;
  logic [7:0]             r_h;
  logic                   r_found;
  logic [7:0]             r_nonce_out;
  logic [7:0]             r_hash_out;
  logic [7:0]             w_byte;
  logic [7:0]             w_next;
  assign w_byte = (r_idx == LAST) ? r_nonce : r_shift[7:0];
  pearson_round u_round (.i_h(r_h), .i_b(w_byte), .o_t(w_next));
  assign busy      = (r_state == HASH) || (r_state == CHECK);
  assign done      = r_state == DONE;
  assign found     = r_found;
  assign nonce_out = r_nonce_out;
  assign hash_out  = r_hash_out;
  // search FSM: header bytes are consumed from a shift copy so the latched header survives for the next nonce
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_hdr       <= '0;
      r_shift     <= '0;
      r_tgt       <= '0;
      r_nonce     <= '0;
      r_idx       <= '0;
      r_h         <= '0;
      r_found     <= 1'b0;
      r_nonce_out <= '0;
      r_hash_out  <= '0;
    end else begin
      unique case (r_state)
        IDLE, DONE: if (start) begin
          r_hdr   <= header;
          r_shift <= header;
          r_tgt   <= target;
          r_nonce <= '0;
          r_idx   <= '0;
          r_h     <= HASH_INIT;
          r_found <= 1'b0;
          r_state <= HASH;
        end
        HASH: begin
          r_h     <= w_next;
          r_idx   <= r_idx + 6'd1;
          r_shift <= r_shift >> 8;
          if (r_idx == LAST) r_state <= CHECK;
        end
        CHECK: begin
          r_hash_out  <= r_h;
          r_nonce_out <= r_nonce;
          if (r_h < r_tgt) begin
            r_found <= 1'b1;
            r_state <= DONE;
          end else if (r_nonce == 8'hFF) begin
            r_found <= 1'b0;
            r_state <= DONE;
          end else begin
            r_nonce <= r_nonce + 8'd1;
            r_idx   <= '0;
            r_h     <= HASH_INIT;
            r_shift <= r_hdr;
            r_state <= HASH;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pow_nonce_miner.sv
// tb_pow_nonce_miner: directed scoreboard bench for the nonce miner
module tb_pow_nonce_miner;
  localparam int MB = 4;
  localparam int LIMIT = 2000;
  typedef struct {
    logic       f;
    logic [7:0] n;
    logic [7:0] h;
    int         cyc;
  } exp_t;
  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [8*MB-1:0] header = '0;
  logic [7:0]    target = '0;
  logic          busy, done, found;
  logic [7:0]    nonce_out, hash_out;
  logic [7:0]    rh, rb, rt;
  int            errors = 0;
  int            checks = 0;
  exp_t          sb[$];
  pow_nonce_miner #(.MSG_BYTES(MB)) dut (
    .clock(clock), .reset(reset), .start(start), .header(header), .target(target),
    .busy(busy), .done(done), .found(found), .nonce_out(nonce_out), .hash_out(hash_out)
  );
  pearson_round u_rnd (.i_h(rh), .i_b(rb), .o_t(rt));
  always #5 clock = ~clock;
  function automatic logic [7:0] tb_t(input logic [7:0] x);
    logic [7:0] a, b;
    a = 8'((int'(x) * 167 + 13) % 256);
    b = {a[2:0], a[7:3]} ^ 8'h5C;
    return 8'((int'(b) * 29 + 101) % 256);
  endfunction
  function automatic logic [7:0] ghash(input logic [8*MB-1:0] hdr, input logic [7:0] n);
    logic [7:0] h;
    h = 8'hAA;
    for (int i = 0; i < MB; i++) h = tb_t(h ^ hdr[8*i +: 8]);
    return tb_t(h ^ n);
  endfunction
  function automatic exp_t golden(input logic [8*MB-1:0] hdr, input logic [7:0] tgt);
    exp_t e;
    for (int k = 0; k < 256; k++) begin
      e.h = ghash(hdr, 8'(k));
      if (e.h < tgt) begin
        e.f = 1'b1;
        e.n = 8'(k);
        e.cyc = (k + 1) * (MB + 2);
        return e;
      end
    end
    e.f = 1'b0;
    e.n = 8'hFF;
    e.h = ghash(hdr, 8'hFF);
    e.cyc = 256 * (MB + 2);
    return e;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic launch(input logic [8*MB-1:0] hdr, input logic [7:0] tgt, input bit hold);
    @(negedge clock);
    header = hdr;
    target = tgt;
    start = 1'b1;
    sb.push_back(golden(hdr, tgt));
    @(posedge clock);
    #1;
    if (!hold) start = 1'b0;
  endtask
  task automatic finish_check(input string tag, input bit timing);
    int n, bc;
    exp_t e;
    n = 0;
    bc = 0;
    while (done !== 1'b1 && n < LIMIT) begin
      bc += int'(busy);
      @(posedge clock);
      #1;
      n++;
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    e = sb.pop_front();
    chk({tag, "_found"}, 32'(found), 32'(e.f));
    chk({tag, "_nonce"}, 32'(nonce_out), 32'(e.n));
    chk({tag, "_hash"}, 32'(hash_out), 32'(e.h));
    if (timing) begin
      chk({tag, "_cycles"}, 32'(n), 32'(e.cyc));
      chk({tag, "_busy_cycles"}, 32'(bc), 32'(e.cyc));
    end
  endtask
  initial begin
    logic [8*MB-1:0] hdr;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_found", 32'(found), 32'd0);
    chk("rst_nonce", 32'(nonce_out), 32'd0);
    chk("rst_hash", 32'(hash_out), 32'd0);
    for (int i = 0; i < 6; i++) begin
      rh = 8'($urandom);
      rb = 8'($urandom);
      #1;
      chk("round", 32'(rt), 32'(tb_t(rh ^ rb)));
    end
    hdr = 32'h01020304;
    if (ghash(hdr, 8'h00) == 8'hFF) hdr = 32'h01020305;
    launch(hdr, 8'hFF, 1'b0);
    finish_check("first", 1'b1);
    chk("first_nonce0", 32'(nonce_out), 32'd0);
    launch(32'hDEADBEEF, 8'h00, 1'b0);
    finish_check("exhaust", 1'b1);
    for (int i = 0; i < 5; i++) begin
      launch($urandom, 8'h10, 1'b0);
      finish_check("rand", 1'b1);
    end
    launch(32'hCAFEF00D, 8'h00, 1'b0);
    repeat (19) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_found", 32'(found), 32'd0);
    chk("midrst_nonce", 32'(nonce_out), 32'd0);
    chk("midrst_hash", 32'(hash_out), 32'd0);
    void'(sb.pop_front());
    reset = 1'b0;
    launch(32'h13579BDF, 8'h20, 1'b0);
    finish_check("after_rst", 1'b1);
    launch(32'h2468ACE0, 8'h08, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    header = 32'hFFFF0000;
    target = 8'hFF;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    finish_check("ignore_start", 1'b0);
    launch(32'h0BADF00D, 8'h40, 1'b1);
    finish_check("hold_a", 1'b1);
    sb.push_back(golden(32'h0BADF00D, 8'h40));
    @(posedge clock);
    #1;
    chk("hold_done_pulse", 32'(done), 32'd0);
    chk("hold_restart_busy", 32'(busy), 32'd1);
    start = 1'b0;
    finish_check("hold_b", 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
